// File: rtl/icache_pkg.sv
// Shared types, constants and address-split helpers for the instruction
// fetch cache.
//   fetch_state_t : refill FSM states (IDLE, FILL, WRITE)
//   NOP_INST      : word presented to decode while the fetch is stalled
//   pc_offset/pc_index/pc_tag : split a byte address into its line offset,
//                               line index and tag fields
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Byte offset within a line (low off_w bits of pc).
    function automatic logic [31:0] pc_offset(input logic [31:0] pc, input int off_w);
        return pc & ((32'd1 << off_w) - 32'd1);
    endfunction

    // Line index (the idx_w bits just above the offset).
    function automatic logic [31:0] pc_index(input logic [31:0] pc, input int off_w, input int idx_w);
        return (pc >> off_w) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    // Tag (everything above offset and index).
    function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int off_w, input int idx_w);
        return pc >> (off_w + idx_w);
    endfunction

endpackage

// File: rtl/instruction_fetch_cache_if.sv
// Byte-wide DRAM read port used to refill the instruction cache.
//   imem_dram_req   : byte read request, held until accepted
//   imem_dram_addr  : byte address of the current request
//   imem_dram_ready : request accepted and data valid this cycle
//   imem_dram_data  : returned byte
// master = cache side, slave = memory side.
interface instruction_fetch_cache_if;
    logic        imem_dram_req;
    logic [31:0] imem_dram_addr;
    logic        imem_dram_ready;
    logic [7:0]  imem_dram_data;

    modport master (output imem_dram_req, output imem_dram_addr,
                    input  imem_dram_ready, input imem_dram_data);
    modport slave  (input  imem_dram_req, input imem_dram_addr,
                    output imem_dram_ready, output imem_dram_data);
endinterface

// File: rtl/icache_data_array.sv
// Line, tag and valid storage for the direct-mapped instruction cache.
//   clk, rst    : clock, synchronous active-high reset (clears valid bits)
//   i_clr_all   : clear every valid bit; wins over a same-cycle valid set
//   i_rd_index  : combinational read port -> o_rd_line/o_rd_tag/o_rd_valid
//   i_wr_en     : synchronous line write of i_wr_line/i_wr_tag at i_wr_index,
//                 valid bit loaded from i_wr_valid
module icache_data_array #(
    parameter int NUM_LINES  = 16,
    parameter int LINE_BYTES = 16,
    parameter int TAG_W      = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_clr_all,
    input  logic [$clog2(NUM_LINES)-1:0] i_rd_index,
    output logic [LINE_BYTES*8-1:0]      o_rd_line,
    output logic [TAG_W-1:0]             o_rd_tag,
    output logic                         o_rd_valid,
    input  logic                         i_wr_en,
    input  logic [$clog2(NUM_LINES)-1:0] i_wr_index,
    input  logic [LINE_BYTES*8-1:0]      i_wr_line,
    input  logic [TAG_W-1:0]             i_wr_tag,
    input  logic                         i_wr_valid
);
    logic [LINE_BYTES*8-1:0] r_data [NUM_LINES];
    logic [TAG_W-1:0]        r_tag  [NUM_LINES];
    logic [NUM_LINES-1:0]    r_valid;

    assign o_rd_line  = r_data[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_valid = r_valid[i_rd_index];

    // Line data and tag write; contents are meaningless until validated.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_data[i_wr_index] <= i_wr_line;
            r_tag[i_wr_index]  <= i_wr_tag;
        end else begin
            r_data[i_wr_index] <= r_data[i_wr_index];
            r_tag[i_wr_index]  <= r_tag[i_wr_index];
        end
    end

    // Valid bits: reset and clear-all take priority over a line write.
    always_ff @(posedge clk) begin
        if (rst || i_clr_all) begin
            r_valid <= {NUM_LINES{1'b0}};
        end else if (i_wr_en) begin
            r_valid[i_wr_index] <= i_wr_valid;
        end else begin
            r_valid <= r_valid;
        end
    end
endmodule

// File: rtl/instruction_fetch_cache.sv
// Fetch stage: direct-mapped read-only instruction cache with a byte-serial
// refill from DRAM. Hits return the instruction in the same cycle as PC.
//   clk, rst      : clock, synchronous active-high reset
//   PC            : fetch address (PC[1:0] ignored)
//   icache_flush  : one-cycle pulse invalidating every line
//   inst          : instruction for PC, NOP_INST while stalled
//   icache_stall  : miss or refill in progress
//   dram          : byte-wide refill port (master side)
module instruction_fetch_cache
    import icache_pkg::*;
#(
    parameter int          NUM_LINES  = 16,
    parameter int          LINE_BYTES = 16,
    parameter logic [31:0] NOP_INST   = icache_pkg::NOP_INST
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [31:0]                        PC,
    input  logic                               icache_flush,
    output logic [31:0]                        inst,
    output logic                               icache_stall,
    instruction_fetch_cache_if.master          dram
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;
    localparam int LINE_W = LINE_BYTES * 8;
    localparam logic [OFF_W-1:0] CNT_LAST = OFF_W'(LINE_BYTES - 1);
    localparam logic [OFF_W-1:0] CNT_ONE  = OFF_W'(1);
    localparam logic [31:0]      OFF_MASK = 32'(LINE_BYTES - 1);

    fetch_state_t      r_state;
    logic [OFF_W-1:0]  r_count;
    logic [31:0]       r_base;
    logic [LINE_W-1:0] r_line;
    logic              r_poison;

    logic [IDX_W-1:0]  w_index;
    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_fill_index;
    logic [TAG_W-1:0]  w_fill_tag;
    logic [LINE_W-1:0] w_rd_line;
    logic [TAG_W-1:0]  w_rd_tag;
    logic              w_rd_valid;
    logic              w_hit;
    logic [31:0]       w_shift;
    logic [31:0]       w_word;

    assign w_index      = IDX_W'(pc_index(PC, OFF_W, IDX_W));
    assign w_tag        = TAG_W'(pc_tag(PC, OFF_W, IDX_W));
    assign w_fill_index = IDX_W'(pc_index(r_base, OFF_W, IDX_W));
    assign w_fill_tag   = TAG_W'(pc_tag(r_base, OFF_W, IDX_W));
    assign w_hit        = w_rd_valid && (w_rd_tag == w_tag);
    // Word-aligned bit position of the addressed word inside the line.
    assign w_shift      = (pc_offset(PC, OFF_W) & ~32'd3) << 3;
    assign w_word       = 32'(w_rd_line >> w_shift);

    icache_data_array #(
        .NUM_LINES (NUM_LINES),
        .LINE_BYTES(LINE_BYTES),
        .TAG_W     (TAG_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .i_clr_all (icache_flush),
        .i_rd_index(w_index),
        .o_rd_line (w_rd_line),
        .o_rd_tag  (w_rd_tag),
        .o_rd_valid(w_rd_valid),
        .i_wr_en   (r_state == WRITE),
        .i_wr_index(w_fill_index),
        .i_wr_line (r_line),
        .i_wr_tag  (w_fill_tag),
        .i_wr_valid(!r_poison)
    );

    // Refill FSM: capture the missing line, gather its bytes, commit it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_count  <= {OFF_W{1'b0}};
            r_base   <= 32'd0;
            r_poison <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_hit) begin
                        r_base  <= PC & ~OFF_MASK;
                        r_count <= {OFF_W{1'b0}};
                        r_state <= FILL;
                    end
                end
                FILL: begin
                    // A flush cannot stop the refill, so remember that the
                    // line being gathered must not become valid.
                    if (icache_flush) begin
                        r_poison <= 1'b1;
                    end
                    if (dram.imem_dram_ready) begin
                        r_line[{r_count, 3'd0} +: 8] <= dram.imem_dram_data;
                        r_count <= r_count + CNT_ONE;
                        if (r_count == CNT_LAST) begin
                            r_state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    r_poison <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Output decode; hits are combinational so decode sees inst this cycle.
    always_comb begin
        inst                = NOP_INST;
        icache_stall        = 1'b0;
        dram.imem_dram_req  = 1'b0;
        dram.imem_dram_addr = 32'd0;
        if (rst) begin
            icache_stall = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        inst = w_word;
                    end else begin
                        icache_stall = 1'b1;
                    end
                end
                FILL: begin
                    icache_stall        = 1'b1;
                    dram.imem_dram_req  = 1'b1;
                    dram.imem_dram_addr = r_base + 32'(r_count);
                end
                WRITE: begin
                    icache_stall = 1'b1;
                end
                default: begin
                    icache_stall = 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch_cache.sv
// Directed bench for instruction_fetch_cache: cold miss, spatial hits,
// DRAM wait states, conflict miss, flush during refill, reset during refill.
module tb_instruction_fetch_cache;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC;
    logic        icache_flush;
    logic [31:0] inst;
    logic        icache_stall;

    int n_pass  = 0;
    int n_total = 0;
    int stalls, accepts, bad_addr;

    instruction_fetch_cache_if dram_if ();

    instruction_fetch_cache #(
        .NUM_LINES (16),
        .LINE_BYTES(16),
        .NOP_INST  (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .PC          (PC),
        .icache_flush(icache_flush),
        .inst        (inst),
        .icache_stall(icache_stall),
        .dram        (dram_if.master)
    );

    always #5 clk = ~clk;

    // DRAM contents: 13 00 00 00 at 0..3, elsewhere (a[7:0]^A5)+a[15:8].
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        if (a < 32'd4) return (a == 32'd0) ? 8'h13 : 8'h00;
        return (lo ^ 8'hA5) + a[15:8];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Serve a refill: ready every (gap+1) requested cycles, optional one-shot
    // flush when flush_at bytes have been accepted, optional early return
    // when stop_at bytes have been accepted. Counts stalled cycles, accepted
    // bytes and request addresses that do not match base + (accepts mod 16).
    task automatic fetch_miss(input logic [31:0] base, input int gap, input int flush_at,
                              input int stop_at, output int n_stall, output int n_acc,
                              output int n_bad);
        int  wc;
        bit  acc;
        bit  flushed;
        n_stall = 0; n_acc = 0; n_bad = 0; wc = 0; flushed = 1'b0;
        #1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!icache_stall) break;
            if (n_acc == stop_at) break;
            n_stall++;
            acc = 1'b0;
            if (!flushed && n_acc == flush_at && dram_if.imem_dram_req) begin
                icache_flush = 1'b1;
                flushed = 1'b1;
            end
            if (dram_if.imem_dram_req) begin
                if (dram_if.imem_dram_addr !== base + 32'(n_acc % 16)) n_bad++;
                if (wc == gap) begin
                    acc = 1'b1;
                    wc  = 0;
                end else begin
                    wc++;
                end
            end
            dram_if.imem_dram_ready = acc;
            dram_if.imem_dram_data  = acc ? mem_byte(dram_if.imem_dram_addr) : 8'h00;
            @(posedge clk);
            if (acc) n_acc++;
            @(negedge clk);
            #1;
            icache_flush = 1'b0;
            dram_if.imem_dram_ready = 1'b0;
            #1;
        end
        dram_if.imem_dram_ready = 1'b0;
        icache_flush = 1'b0;
    endtask

    task automatic hit_check(input string tag, input logic [31:0] pc, input logic [31:0] exp);
        PC = pc;
        #1;
        check({tag, "_stall"}, 32'(icache_stall), 32'd0);
        check({tag, "_inst"}, inst, exp);
        check({tag, "_req"}, 32'(dram_if.imem_dram_req), 32'd0);
    endtask

    initial begin
        rst = 1'b1; PC = 32'd0; icache_flush = 1'b0;
        dram_if.imem_dram_ready = 1'b0; dram_if.imem_dram_data = 8'h00;

        // Reset outputs
        settle();
        check("rst_stall", 32'(icache_stall), 32'd0);
        check("rst_inst", inst, 32'h0000_0013);
        check("rst_req", 32'(dram_if.imem_dram_req), 32'd0);
        check("rst_addr", dram_if.imem_dram_addr, 32'd0);
        settle();
        rst = 1'b0;

        // 1. Cold miss at PC=0
        fetch_miss(32'h0, 0, -1, -1, stalls, accepts, bad_addr);
        check("cold_stalls", 32'(stalls), 32'd18);
        check("cold_accepts", 32'(accepts), 32'd16);
        check("cold_addr_order", 32'(bad_addr), 32'd0);
        hit_check("cold_hit", 32'h0, 32'h0000_0013);

        // 2. Spatial hits in the same line
        settle(); hit_check("hit4", 32'h4, 32'hA2A3_A0A1);
        settle(); hit_check("hit8", 32'h8, 32'hAEAF_ACAD);
        settle(); hit_check("hit12", 32'hC, 32'hAAAB_A8A9);

        // 3. Wait states: ready every third cycle, also conflicts with line 0
        settle(); PC = 32'h100;
        fetch_miss(32'h100, 2, -1, -1, stalls, accepts, bad_addr);
        check("wait_stalls", 32'(stalls), 32'd50);
        check("wait_accepts", 32'(accepts), 32'd16);
        check("wait_addr_hold", 32'(bad_addr), 32'd0);
        hit_check("wait_hit", 32'h100, 32'hA7A8_A5A6);
        settle(); hit_check("wait_hit104", 32'h104, 32'hA3A4_A1A2);

        // 4. Conflict: PC=0 was overwritten by 0x100
        settle(); PC = 32'h0; #1;
        check("conf_miss", 32'(icache_stall), 32'd1);
        fetch_miss(32'h0, 0, -1, -1, stalls, accepts, bad_addr);
        check("conf_stalls", 32'(stalls), 32'd18);
        check("conf_addr", 32'(bad_addr), 32'd0);
        hit_check("conf_hit", 32'h0, 32'h0000_0013);

        // 5. Flush at counter=5; line 0x10 (index 1) must be lost too
        settle(); PC = 32'h10;
        fetch_miss(32'h10, 0, -1, -1, stalls, accepts, bad_addr);
        check("l1_stalls", 32'(stalls), 32'd18);
        hit_check("l1_hit", 32'h10, 32'hB6B7_B4B5);
        settle(); PC = 32'h200;
        fetch_miss(32'h200, 0, 5, -1, stalls, accepts, bad_addr);
        check("flush_stalls", 32'(stalls), 32'd36);
        check("flush_accepts", 32'(accepts), 32'd32);
        check("flush_addr", 32'(bad_addr), 32'd0);
        hit_check("flush_hit", 32'h200, 32'hA8A9_A6A7);
        settle(); PC = 32'h10; #1;
        check("flush_old_miss", 32'(icache_stall), 32'd1);
        fetch_miss(32'h10, 0, -1, -1, stalls, accepts, bad_addr);
        check("flush_old_stalls", 32'(stalls), 32'd18);

        // 6. Reset at counter=7
        settle(); PC = 32'h0;
        fetch_miss(32'h0, 0, -1, 7, stalls, accepts, bad_addr);
        check("mid_req", 32'(dram_if.imem_dram_req), 32'd1);
        check("mid_addr", dram_if.imem_dram_addr, 32'd7);
        rst = 1'b1; #1;
        check("mrst_req", 32'(dram_if.imem_dram_req), 32'd0);
        check("mrst_stall", 32'(icache_stall), 32'd0);
        check("mrst_inst", inst, 32'h0000_0013);
        settle();
        check("mrst_stall2", 32'(icache_stall), 32'd0);
        check("mrst_addr2", dram_if.imem_dram_addr, 32'd0);
        rst = 1'b0;
        fetch_miss(32'h0, 0, -1, -1, stalls, accepts, bad_addr);
        check("restart_stalls", 32'(stalls), 32'd18);
        check("restart_addr", 32'(bad_addr), 32'd0);
        hit_check("restart_hit", 32'h0, 32'h0000_0013);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_cache.md
Name: instruction_fetch_cache

Overview:
Fetch stage directly upstream of instruction decode. It maps the decode-owned PC to a 32-bit instruction word through a small direct-mapped, read-only instruction cache. On a miss it raises a stall so the pipeline freezes. It then refills the line one byte at a time from the byte-wide DRAM port.

Parameters:
NUM_LINES, 16, number of cache lines (power of 2, at least 2)
LINE_BYTES, 16, bytes per line (power of 2, at least 4)
NOP_INST, 32'h00000013, word driven on inst while not hitting (addi x0,x0,0)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous active-high reset
PC  input  32  fetch address from decode; PC[1:0] ignored
icache_flush  input  1  one-cycle pulse; invalidates every line
inst  output  32  instruction for PC; valid when icache_stall=0
icache_stall  output  1  high while PC misses or a refill is in progress; ORed into freeze_cpu at top level
imem_dram_req  output  1  byte read request, held until accepted
imem_dram_addr  output  32  byte address of the current request
imem_dram_ready  input  1  request accepted and data valid this cycle
imem_dram_data  input  8  returned byte, sampled when ready=1

Behaviour:
- Address split:
  - offset = PC[log2(LINE_BYTES)-1:0]
  - index = next log2(NUM_LINES) bits
  - tag = remaining upper bits
- Lookup is combinational. hit = valid[index] && tag_array[index]==tag.
- Reset (rst=1 at posedge):
  - state=IDLE, all valid bits cleared, byte counter=0.
  - While rst=1: icache_stall=0, inst=NOP_INST, imem_dram_req=0, imem_dram_addr=0.
  - A reset mid-refill aborts the refill. The partial line is never validated.
- FSM states: IDLE, FILL, WRITE.
  - IDLE, hit: inst = word at offset (little-endian bytes), icache_stall=0. This gives zero-cycle hit latency, so decode latches inst in the same cycle PC is presented.
  - IDLE, miss: icache_stall=1, inst=NOP_INST. Capture line base (PC with offset zeroed) and tag. Clear the counter. Next state is FILL.
  - FILL:
    - imem_dram_req=1, imem_dram_addr = line base + counter.
    - On a posedge with ready=1: store the byte into the line buffer at position counter, then increment counter.
    - When the byte at counter=LINE_BYTES-1 is accepted, next state is WRITE.
    - req stays high across consecutive bytes; no idle cycle is inserted between bytes.
  - WRITE: copy the line buffer into the data array and set tag_array[index]. Set valid[index] unless it is poisoned (see flush rules). Next state is IDLE, where lookup repeats.
- icache_stall=1 in FILL and WRITE, and in IDLE on a miss. inst=NOP_INST whenever icache_stall=1.
- Miss penalty with a DRAM that accepts every cycle: 1 + LINE_BYTES + 1 cycles of stall, which is 18 with defaults. The first non-stalled cycle is the hit.
- PC is frozen by the stall, so refill uses the captured address. If PC differs on return to IDLE, a normal lookup decides hit or miss.
- Flush rules:
  - Flush in IDLE or WRITE: all valid bits clear at that posedge, and clearing has priority over a WRITE set.
  - Flush during FILL: clear all valid bits and set a poison flag. The refill completes, but WRITE leaves the line invalid and clears poison. The PC then misses again and refetches.
- Conflict miss: a new tag at the same index overwrites the line. There is no write path; the cache is read-only.
- Counter width is log2(LINE_BYTES). Address arithmetic is 32-bit with no wrap handling needed, because the base is line-aligned.

Decomposition:
- Package icache_pkg holds:
  - enum fetch_state_t {IDLE, FILL, WRITE}
  - localparam NOP_INST
  - functions for tag, index and offset extraction given the parameters
- One sub-module, icache_data_array:
  - NUM_LINES x LINE_BYTES*8 storage, with tag and valid arrays.
  - Combinational read port, synchronous line write port, and synchronous clear-all.

Test Plan:
1. Cold miss: rst then PC=0, DRAM returns bytes 13 00 00 00 ... with ready every cycle. Required: stall=1 for 18 cycles, req addresses 0..15 in order, then stall=0 and inst=32'h00000013.
2. Spatial hit: after scenario 1, step PC=4, 8, 12. Required: stall=0 each cycle and inst equals bytes 4-7, 8-11, 12-15 assembled little-endian. No req.
3. Wait states: DRAM ready only every 3rd cycle during a miss at PC=0x100. Required: addr holds each value until ready, 16 accepts, stall drops one cycle after WRITE, data correct.
4. Conflict: fill PC=0x000, then PC=0x100 (same index 0). Required: 0x100 refills and overwrites. Returning to PC=0x000 misses again with a new req at addr 0x000.
5. Flush mid-fill: assert icache_flush when counter=5. Required: the fill finishes all 16 bytes, then IDLE misses again and re-requests the same line. Previously valid lines also miss.
6. Reset mid-fill: rst=1 at counter=7. Required: req=0 and stall=0 during reset. After release, PC=0 misses and the fill restarts at addr 0.
